// File: rtl/banked_bus_memory.sv
// Single-port synchronous bus memory with request/ready/ack handshake and programmable wait states.
// Optional `RESET_VECTOR_EN overlays RESET_VECTOR onto reads of addresses depth-4 / depth-3.
//
// state     | meaning
// ST_IDLE   | ready=1, waiting for write_enable or output_enable
// ST_WAIT   | counting down WAIT_STATES stall cycles
// ST_ACCESS | perform latched op on the leaving edge, pulse ack
module banked_bus_memory #(
   parameter int          ADDR_WIDTH    = 13,
   parameter int          DATA_WIDTH    = 8,
   parameter int          WAIT_STATES   = 1,
   parameter int          ROM_MODE      = 0,
   parameter string       MEM_INIT_FILE = "",
   parameter logic [15:0] RESET_VECTOR  = 16'h8000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  write_enable,
   input  logic                  output_enable,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  ready,
   output logic                  ack,
   output logic                  write_fault
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS} state_t;

   state_t                state;
   logic [3:0]            cnt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  op_write;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

`ifdef RESET_VECTOR_EN
   localparam logic [ADDR_WIDTH-1:0] VEC_LO = ADDR_WIDTH'(DEPTH - 4);
   localparam logic [ADDR_WIDTH-1:0] VEC_HI = ADDR_WIDTH'(DEPTH - 3);

   // Overlay affects the read path only; the array itself still takes writes.
   always_comb begin
      rd_data = mem[addr_q];
      if (addr_q == VEC_LO)
         rd_data = DATA_WIDTH'(RESET_VECTOR[7:0]);
      else if (addr_q == VEC_HI)
         rd_data = DATA_WIDTH'(RESET_VECTOR[15:8]);
   end
`else
   assign rd_data = mem[addr_q];
`endif

   // Array kept out of the reset domain so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (reset_n && state == ST_ACCESS && op_write && ROM_MODE == 0)
         mem[addr_q] <= data_q;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         op_write    <= 1'b0;
         ready       <= 1'b1;
         ack         <= 1'b0;
         write_fault <= 1'b0;
         data_out    <= '0;
      end else begin
         ack         <= 1'b0;
         write_fault <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (write_enable || output_enable) begin
                  addr_q   <= address;
                  data_q   <= data_in;
                  op_write <= write_enable;
                  ready    <= 1'b0;
                  if (WAIT_STATES > 0) begin
                     state <= ST_WAIT;
                     cnt   <= 4'(WAIT_STATES);
                  end else begin
                     state <= ST_ACCESS;
                  end
               end
            end
            ST_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1)
                  state <= ST_ACCESS;
            end
            ST_ACCESS: begin
               ack   <= 1'b1;
               ready <= 1'b1;
               state <= ST_IDLE;
               if (op_write)
                  write_fault <= (ROM_MODE != 0);
               else
                  data_out <= rd_data;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_banked_bus_memory.sv
// Directed bench: RAM with 2 wait states, RAM with 0 wait states, ROM with 1 wait state.
module tb_banked_bus_memory;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        we    [3];
    logic        oe    [3];
    logic [12:0] addr  [3];
    logic [7:0]  din   [3];
    logic [7:0]  dout  [3];
    logic        rdy   [3];
    logic        ack   [3];
    logic        wfault[3];

    int checks = 0;
    int errors = 0;
    int lat;
    int cnt_ack;
    logic wf;

    always #5 clk = ~clk;

    banked_bus_memory #(.WAIT_STATES(2), .ROM_MODE(0)) dut_ram (
        .clk(clk), .reset_n(reset_n), .address(addr[0]), .data_in(din[0]),
        .write_enable(we[0]), .output_enable(oe[0]), .data_out(dout[0]),
        .ready(rdy[0]), .ack(ack[0]), .write_fault(wfault[0]));

    banked_bus_memory #(.WAIT_STATES(0), .ROM_MODE(0)) dut_fast (
        .clk(clk), .reset_n(reset_n), .address(addr[1]), .data_in(din[1]),
        .write_enable(we[1]), .output_enable(oe[1]), .data_out(dout[1]),
        .ready(rdy[1]), .ack(ack[1]), .write_fault(wfault[1]));

    banked_bus_memory #(.WAIT_STATES(1), .ROM_MODE(1)) dut_rom (
        .clk(clk), .reset_n(reset_n), .address(addr[2]), .data_in(din[2]),
        .write_enable(we[2]), .output_enable(oe[2]), .data_out(dout[2]),
        .ready(rdy[2]), .ack(ack[2]), .write_fault(wfault[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // lat = negedges after the accepting edge until ack is seen (WAIT_STATES+1 expected)
    task automatic access(input int k, input logic w, input logic r, input logic [12:0] a,
                          input logic [7:0] d, output int l, output logic f);
        @(negedge clk);
        we[k] = w; oe[k] = r; addr[k] = a; din[k] = d;
        @(negedge clk);
        we[k] = 1'b0; oe[k] = 1'b0;
        l = 0;
        while (ack[k] !== 1'b1 && l < 40) begin
            @(negedge clk);
            l++;
        end
        f = wfault[k];
    endtask

    task automatic count_acks(input int k, input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (ack[k] === 1'b1) c++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            we[i] = 1'b0; oe[i] = 1'b0; addr[i] = '0; din[i] = '0;
        end
        #1;
        dut_rom.mem[16] = 8'hEA;

        // T1 reset
        repeat (2) @(negedge clk);
        chk("rst_ready", rdy[0], 1);
        chk("rst_ack", ack[0], 0);
        chk("rst_wf", wfault[0], 0);
        chk("rst_dout", dout[0], 8'h00);
        chk("rst_ready_fast", rdy[1], 1);
        chk("rst_dout_rom", dout[2], 8'h00);
        reset_n = 1'b1;

        // T2 RAM, 2 wait states
        access(0, 1, 0, 13'h0123, 8'hA5, lat, wf);
        chk("t2_wr_lat", lat, 3);
        chk("t2_wr_dout", dout[0], 8'h00);
        chk("t2_wr_wf", wf, 0);
        @(negedge clk);
        chk("t2_ack_pulse", ack[0], 0);
        access(0, 0, 1, 13'h0123, 8'h00, lat, wf);
        chk("t2_rd_lat", lat, 3);
        chk("t2_rd_dout", dout[0], 8'hA5);

        // T3 zero wait states, enables held
        access(1, 1, 0, 13'h0000, 8'h11, lat, wf);
        chk("t3_wr_lat", lat, 1);
        access(1, 1, 0, 13'h0001, 8'h22, lat, wf);
        @(negedge clk);
        oe[1] = 1'b1; addr[1] = 13'h0000;
        chk("t3_ready0", rdy[1], 1);
        @(negedge clk);
        chk("t3_ready1", rdy[1], 0);
        chk("t3_ack1", ack[1], 0);
        addr[1] = 13'h0001;
        @(negedge clk);
        chk("t3_ack2", ack[1], 1);
        chk("t3_ready2", rdy[1], 1);
        chk("t3_dout2", dout[1], 8'h11);
        @(negedge clk);
        chk("t3_ready3", rdy[1], 0);
        chk("t3_ack3", ack[1], 0);
        @(negedge clk);
        chk("t3_ack4", ack[1], 1);
        chk("t3_dout4", dout[1], 8'h22);
        oe[1] = 1'b0;

        // T4 ROM
        access(2, 1, 0, 13'h0010, 8'h55, lat, wf);
        chk("t4_wr_lat", lat, 2);
        chk("t4_wr_fault", wf, 1);
        @(negedge clk);
        chk("t4_fault_pulse", wfault[2], 0);
        access(2, 0, 1, 13'h0010, 8'h00, lat, wf);
        chk("t4_rd_dout", dout[2], 8'hEA);
        chk("t4_rd_fault", wf, 0);

        // T5 both enables: write wins
        access(0, 1, 1, 13'h0040, 8'h77, lat, wf);
        chk("t5_both_dout", dout[0], 8'hA5);
        access(0, 0, 1, 13'h0040, 8'h00, lat, wf);
        chk("t5_both_rd", dout[0], 8'h77);

        // request pulsed while busy is ignored
        @(negedge clk);
        we[0] = 1'b1; addr[0] = 13'h0040; din[0] = 8'h11;
        @(negedge clk);
        chk("t5_busy", rdy[0], 0);
        addr[0] = 13'h0123; din[0] = 8'hEE;
        @(negedge clk);
        we[0] = 1'b0;
        count_acks(0, 8, cnt_ack);
        chk("t5_single_ack", cnt_ack, 1);
        access(0, 0, 1, 13'h0123, 8'h00, lat, wf);
        chk("t5_ignored", dout[0], 8'hA5);
        access(0, 0, 1, 13'h0040, 8'h00, lat, wf);
        chk("t5_accepted", dout[0], 8'h11);

        // reset mid-WAIT on a write
        @(negedge clk);
        we[0] = 1'b1; addr[0] = 13'h0040; din[0] = 8'h99;
        @(negedge clk);
        we[0] = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        count_acks(0, 6, cnt_ack);
        chk("t5_abort_noack", cnt_ack, 0);
        chk("t5_abort_ready", rdy[0], 1);
        chk("t5_abort_dout", dout[0], 8'h00);
        access(0, 0, 1, 13'h0040, 8'h00, lat, wf);
        chk("t5_abort_mem", dout[0], 8'h11);

        // T6 vector overlay
        access(0, 1, 0, 13'h1FFC, 8'h3C, lat, wf);
        access(0, 1, 0, 13'h1FFD, 8'hC3, lat, wf);
        access(0, 0, 1, 13'h1FFC, 8'h00, lat, wf);
`ifdef RESET_VECTOR_EN
        chk("t6_vec_lo", dout[0], 8'h00);
`else
        chk("t6_vec_lo", dout[0], 8'h3C);
`endif
        access(0, 0, 1, 13'h1FFD, 8'h00, lat, wf);
`ifdef RESET_VECTOR_EN
        chk("t6_vec_hi", dout[0], 8'h80);
`else
        chk("t6_vec_hi", dout[0], 8'hC3);
`endif
        access(0, 0, 1, 13'h1FFE, 8'h00, lat, wf);
        chk("t6_lat", lat, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
